// File: rtl/digitube_pkg.sv
// Shared display constants and types for the 7-segment board display path.
// Segments and anodes are active-low throughout.
package digitube_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0]            seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam an_t  AN_OFF    = 4'hF;

endpackage

// File: rtl/digitube_pwm_thr.sv
// Brightness latch and PWM threshold: thr = ((bright_q+1)*SLOT_CYCLES)>>4.
// Latency: thr follows the load edge combinationally from bright_q; backpressure: none.
module digitube_pwm_thr
  import digitube_pkg::*;
#(
  parameter int SLOT_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             sysclk,
  input  logic             Reset_n,
  input  logic             load_i,
  input  logic [3:0]       bright_i,
  output logic [CNT_W:0]   thr_o
);

  // One extra bit over CNT_W+4 so SLOT_CYCLES == 2**CNT_W cannot overflow.
  localparam int PW = CNT_W + 5;

  logic [3:0]    bright_q;
  logic [3:0]    bright_d;
  logic [PW-1:0] prod;

  always_comb begin
    bright_d = load_i ? bright_i : bright_q;
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      bright_q <= 4'hF;
    end else begin
      bright_q <= bright_d;
    end
  end

  always_comb begin
    prod  = PW'({1'b0, bright_q} + 5'd1) * PW'(SLOT_CYCLES);
    thr_o = (CNT_W+1)'(prod >> 4);
  end

endmodule

// File: rtl/digitube_mux.sv
// Time-multiplexed 4-digit 7-segment driver with frame snapshot, guard band and PWM.
// Latency: outputs registered 1 cycle after counter state; backpressure: none (free-running scan).
module digitube_mux
  import digitube_pkg::*;
#(
  parameter int SLOT_CYCLES = 50000,
  parameter int GUARD       = 64,
  parameter int CNT_W       = 16
) (
  input  logic       sysclk,
  input  logic       Reset_n,
  input  logic [6:0] digi_in1,
  input  logic [6:0] digi_in2,
  input  logic [6:0] digi_in3,
  input  logic [6:0] digi_in4,
  input  logic       enable,
  input  logic [3:0] brightness,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  // Guard beyond the slot length behaves identically to a guard of exactly one slot.
  localparam int unsigned      GUARD_CL  = (GUARD > SLOT_CYCLES) ? SLOT_CYCLES : GUARD;
  localparam logic [CNT_W:0]   GUARD_L   = (CNT_W+1)'(GUARD_CL);

  logic [CNT_W-1:0]            slot_cnt_q, slot_cnt_d;
  logic [1:0]                  idx_q, idx_d;
  logic                        en_q;
  seg_t [NUM_DIGITS-1:0]       snap_q, snap_d;
  seg_t                        seg_q, seg_d;
  an_t                         an_q, an_d;
  logic                        tick_q, tick_d;
  logic                        frame_start;
  logic                        lit;
  logic [CNT_W:0]              thr;

  digitube_pwm_thr #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_pwm_thr (
    .sysclk   (sysclk),
    .Reset_n  (Reset_n),
    .load_i   (frame_start),
    .bright_i (brightness),
    .thr_o    (thr)
  );

  assign frame_start = enable && (!en_q || (slot_cnt_q == SLOT_LAST && idx_q == 2'd3));
  assign lit = ({1'b0, slot_cnt_q} >= GUARD_L) && ({1'b0, slot_cnt_q} < thr);

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    seg_d      = SEG_BLANK;
    an_d       = AN_OFF;
    tick_d     = frame_start;

    // Counters sit at zero while dark and through the enable-rise boundary cycle.
    if (!enable || !en_q) begin
      slot_cnt_d = '0;
      idx_d      = '0;
    end else if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
    end

    if (frame_start) begin
      snap_d = {digi_in4, digi_in3, digi_in2, digi_in1};
    end

    if (enable) begin
      seg_d = snap_q[idx_q];
      if (lit) begin
        an_d[idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      en_q       <= 1'b0;
      snap_q     <= {NUM_DIGITS{SEG_BLANK}};
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      en_q       <= enable;
      snap_q     <= snap_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_digitube_mux.sv
// Bench for digitube_mux: frame-position reference model checked every cycle plus directed literals.
module tb_digitube_mux;

  localparam int SLOT  = 16;
  localparam int GUARD = 2;
  localparam int CNT_W = 5;
  localparam int FRAME = 4 * SLOT;

  logic       sysclk = 1'b0;
  logic       Reset_n;
  logic [6:0] digi_in1, digi_in2, digi_in3, digi_in4;
  logic       enable;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic       frame_tick;

  always #5 sysclk = ~sysclk;

  digitube_mux #(
    .SLOT_CYCLES (SLOT),
    .GUARD       (GUARD),
    .CNT_W       (CNT_W)
  ) dut (
    .sysclk     (sysclk),
    .Reset_n    (Reset_n),
    .digi_in1   (digi_in1),
    .digi_in2   (digi_in2),
    .digi_in3   (digi_in3),
    .digi_in4   (digi_in4),
    .enable     (enable),
    .brightness (brightness),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Reference model: position within the current frame (0..FRAME-1) drives everything.
  logic [6:0] m_snap [4];
  int         m_t;
  bit         m_run;
  int         m_thr;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_tick;
  logic       m_bound;

  assign m_bound = enable && (!m_run || m_t == FRAME - 1);

  always @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) m_snap[i] <= 7'h7F;
      m_t      <= 0;
      m_run    <= 1'b0;
      m_thr    <= SLOT;
      exp_seg  <= 7'h7F;
      exp_an   <= 4'hF;
      exp_tick <= 1'b0;
    end else begin
      exp_seg  <= enable ? m_snap[m_t / SLOT] : 7'h7F;
      exp_an   <= (enable && (m_t % SLOT) >= GUARD && (m_t % SLOT) < m_thr)
                  ? ~(4'b0001 << (m_t / SLOT)) : 4'hF;
      exp_tick <= m_bound;
      if (!enable) begin
        m_run <= 1'b0;
        m_t   <= 0;
      end else if (m_bound) begin
        m_run     <= 1'b1;
        m_t       <= 0;
        m_snap[0] <= digi_in1;
        m_snap[1] <= digi_in2;
        m_snap[2] <= digi_in3;
        m_snap[3] <= digi_in4;
        m_thr     <= ((int'(brightness) + 1) * SLOT) / 16;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  int last_tick = -1;

  always @(negedge sysclk) begin
    check("seg_out", 32'(seg_out), 32'(exp_seg));
    check("an_out", 32'(an_out), 32'(exp_an));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    check("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
    if (frame_tick) begin
      if (last_tick >= 0 && cyc > last_tick)
        check("tick_period", 32'(cyc - last_tick), 32'd64);
      last_tick <= cyc;
    end else if (!enable) begin
      last_tick <= -1;
    end
  end

  task automatic at_cycle(input int c);
    int guard = 0;
    while (cyc != c && guard < 2000) begin
      @(negedge sysclk);
      guard++;
    end
    check("reach_cycle", 32'(cyc), 32'(c));
    #1;
  endtask

  initial begin
    Reset_n    = 1'b1;
    enable     = 1'b1;
    brightness = 4'd15;
    digi_in1   = 7'h40;
    digi_in2   = 7'h79;
    digi_in3   = 7'h24;
    digi_in4   = 7'h30;
    #1 Reset_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    #1 Reset_n = 1'b1;

    at_cycle(1);   check("c1_tick", 32'(frame_tick), 32'h1);  check("c1_an", 32'(an_out), 32'hF);
    at_cycle(2);   check("c2_tick", 32'(frame_tick), 32'h0);  check("c2_seg", 32'(seg_out), 32'h40);
    at_cycle(3);   check("c3_guard", 32'(an_out), 32'hF);
    at_cycle(4);   check("c4_an", 32'(an_out), 32'hE);        check("c4_seg", 32'(seg_out), 32'h40);
    at_cycle(17);  check("c17_an", 32'(an_out), 32'hE);
    at_cycle(18);  check("c18_an", 32'(an_out), 32'hF);       check("c18_seg", 32'(seg_out), 32'h79);
    at_cycle(20);  check("c20_an", 32'(an_out), 32'hD);
    at_cycle(30);  check("c30_an", 32'(an_out), 32'hD);
    brightness = 4'd3;
    at_cycle(36);  check("c36_an", 32'(an_out), 32'hB);       check("c36_seg", 32'(seg_out), 32'h24);
    at_cycle(52);  check("c52_an", 32'(an_out), 32'h7);       check("c52_seg", 32'(seg_out), 32'h30);
    at_cycle(65);  check("c65_tick", 32'(frame_tick), 32'h1); check("c65_an", 32'(an_out), 32'h7);

    at_cycle(68);  check("dim_on", 32'(an_out), 32'hE);
    at_cycle(70);  check("dim_off", 32'(an_out), 32'hF);
    digi_in2 = 7'h12;
    at_cycle(84);  check("hold_an", 32'(an_out), 32'hD);      check("hold_seg", 32'(seg_out), 32'h79);
    at_cycle(86);  check("dim_off2", 32'(an_out), 32'hF);
    at_cycle(129); check("c129_tick", 32'(frame_tick), 32'h1);
    at_cycle(148); check("new_an", 32'(an_out), 32'hD);       check("new_seg", 32'(seg_out), 32'h12);

    at_cycle(150);
    enable = 1'b0;
    at_cycle(151); check("dis_an", 32'(an_out), 32'hF);       check("dis_seg", 32'(seg_out), 32'h7F);
    at_cycle(155); check("dis_tick", 32'(frame_tick), 32'h0);
    at_cycle(160);
    enable = 1'b1;
    at_cycle(161); check("reen_tick", 32'(frame_tick), 32'h1);
    at_cycle(162); check("reen_tick_end", 32'(frame_tick), 32'h0);
    at_cycle(164); check("reen_an", 32'(an_out), 32'hE);      check("reen_seg", 32'(seg_out), 32'h40);
    at_cycle(225); check("c225_tick", 32'(frame_tick), 32'h1);

    at_cycle(245); check("pre_rst_an", 32'(an_out), 32'hD);   check("pre_rst_seg", 32'(seg_out), 32'h12);
    Reset_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg_out), 32'h7F);
    check("arst_an", 32'(an_out), 32'hF);
    check("arst_tick", 32'(frame_tick), 32'h0);
    #1 Reset_n = 1'b1;

    at_cycle(1);   check("post_rst_tick", 32'(frame_tick), 32'h1);
    at_cycle(4);   check("post_rst_an", 32'(an_out), 32'hE);
    at_cycle(6);   check("post_rst_dim", 32'(an_out), 32'hF);
    at_cycle(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
